// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and helpers for the 5-stage MIPS pipeline
//                (data width, NOP encoding, PC increment, target alignment).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int              XLEN         = 32;
    // sll $0,$0,0 - the canonical MIPS no-op
    localparam logic [XLEN-1:0] NOP_ENCODING = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC       = 32'd4;

    // Instructions are word aligned; the low two address bits are discarded.
    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : if_perf_cnt
//  Description : Three saturating 32-bit event counters for the fetch stage
//                (valid fetches, stall/wait cycles, redirect flushes).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_perf_cnt
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetchEvt,
    input  logic            stallEvt,
    input  logic            flushEvt,
    output logic [XLEN-1:0] fetchCnt,
    output logic [XLEN-1:0] stallCnt,
    output logic [XLEN-1:0] flushCnt
);

    logic [XLEN-1:0] r_fetchCnt;
    logic [XLEN-1:0] r_stallCnt;
    logic [XLEN-1:0] r_flushCnt;

    // Count each event once per cycle, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchCnt <= '0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (fetchEvt && (r_fetchCnt != '1)) r_fetchCnt <= r_fetchCnt + 1'b1;
            if (stallEvt && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
            if (flushEvt && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign fetchCnt = r_fetchCnt;
    assign stallCnt = r_stallCnt;
    assign flushCnt = r_flushCnt;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : MIPS instruction-fetch stage. Owns the PC and the IF/ID
//                register; applies branch/jump redirects, hazard-unit stalls
//                and instruction-memory wait states.
//                Optional feature macro: IF_PERF_CNT_EN (performance counters;
//                when undefined the perf ports are tied to zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENCODING
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            ifid_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ifidInstr;
    logic [XLEN-1:0] r_ifidPc4;
    logic            r_ifidValid;

    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_nextPc;
    logic            w_jumpAcc;
    logic            w_redirect;

    // A jump sitting in a stalled ID slot has not issued yet, so it is ignored.
    assign w_jumpAcc  = jump_en & ifid_write;
    assign w_redirect = branch_taken | w_jumpAcc;
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0
    assign w_pcPlus4  = r_pc + PC_INC;

    // Next-PC select: branch beats jump, redirects beat stall and memory wait
    always_comb begin
        w_nextPc = w_pcPlus4;
        if (branch_taken) begin
            w_nextPc = alignWord(branch_target);
        end else if (w_jumpAcc) begin
            w_nextPc = alignWord(jump_target);
        end else if (!pc_write || !imem_ready) begin
            w_nextPc = r_pc;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // IF/ID register: flush beats hold, hold beats memory-wait bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifidInstr <= NOP_INSTR;
            r_ifidPc4   <= '0;
            r_ifidValid <= 1'b0;
        end else if (w_redirect) begin
            // pc4 is meaningless for a flushed slot, so it is left alone
            r_ifidInstr <= NOP_INSTR;
            r_ifidValid <= 1'b0;
        end else if (!ifid_write) begin
            // hazard-unit stall: keep the slot exactly as it is
        end else if (!imem_ready) begin
            r_ifidInstr <= NOP_INSTR;
            r_ifidValid <= 1'b0;
        end else begin
            r_ifidInstr <= imem_rdata;
            r_ifidPc4   <= w_pcPlus4;
            r_ifidValid <= 1'b1;
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign ifid_instr = r_ifidInstr;
    assign ifid_pc4   = r_ifidPc4;
    assign ifid_valid = r_ifidValid;

`ifdef IF_PERF_CNT_EN
    logic w_fetchEvt;
    logic w_stallEvt;
    logic w_flushEvt;

    assign w_fetchEvt = !w_redirect & ifid_write & imem_ready;
    assign w_stallEvt = !w_redirect & (!ifid_write | !imem_ready);
    assign w_flushEvt = w_redirect;

    if_perf_cnt u_perfCnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetchEvt (w_fetchEvt),
        .stallEvt (w_stallEvt),
        .flushEvt (w_flushEvt),
        .fetchCnt (perf_fetch_cnt),
        .stallCnt (perf_stall_cnt),
        .flushCnt (perf_flush_cnt)
    );
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage: directed scenarios plus a
//                randomized run against a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0040;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pc_write, ifid_write, branch_taken, jump_en, imem_ready;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_rdata;
    wire  [31:0] imem_addr, pc, ifid_instr, ifid_pc4;
    wire         ifid_valid;
    wire  [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid;
    logic [31:0] mFetch, mStall, mFlush;

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word per address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    function automatic logic [31:0] perfExp(input logic [31:0] v);
        return PERF_ON ? v : 32'h0;
    endfunction

    task automatic setIdle();
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        branch_taken  = 1'b0;
        jump_en       = 1'b0;
        imem_ready    = 1'b1;
        branch_target = 32'h0;
        jump_target   = 32'h0;
    endtask

    task automatic modelReset();
        mPc = RST_PC; mInstr = NOP; mPc4 = 32'h0; mValid = 1'b0;
        mFetch = 0; mStall = 0; mFlush = 0;
    endtask

    // Advance one clock; the model applies the fetch rules to the inputs
    // currently driven, then outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        logic        redirect, jacc;
        logic [31:0] nPc, nInstr, nPc4;
        logic        nValid;
        jacc     = jump_en && ifid_write;
        redirect = branch_taken || jacc;
        if (branch_taken)                 nPc = branch_target & 32'hFFFF_FFFC;
        else if (jacc)                    nPc = jump_target & 32'hFFFF_FFFC;
        else if (!pc_write || !imem_ready) nPc = mPc;
        else                              nPc = mPc + 32'd4;
        nInstr = mInstr; nPc4 = mPc4; nValid = mValid;
        if (redirect) begin
            nInstr = NOP; nValid = 1'b0;
            if (mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 1;
        end else if (!ifid_write || !imem_ready) begin
            if (ifid_write) begin nInstr = NOP; nValid = 1'b0; end
            if (mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
        end else begin
            nInstr = memWord(mPc); nPc4 = mPc + 32'd4; nValid = 1'b1;
            if (mFetch != 32'hFFFF_FFFF) mFetch = mFetch + 1;
        end
        @(posedge clk);
        #1;
        mPc = nPc; mInstr = nInstr; mPc4 = nPc4; mValid = nValid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIdle();
        modelReset();
        #12;
        total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
        total++; if (ifid_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc4); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        total++; if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
            bad++; $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL seq_addr0 got=%h exp=100", imem_addr); end
        cycle();
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL seq_addr1 got=%h exp=104", imem_addr); end
        total++; if (ifid_pc4 !== 32'h104 || ifid_valid !== 1'b1 || ifid_instr !== memWord(32'h100)) begin
            bad++; $display("FAIL seq_ifid1 got=%h/%b/%h exp=104/1/%h", ifid_pc4, ifid_valid, ifid_instr, memWord(32'h100));
        end
        cycle();
        total++; if (imem_addr !== 32'h108) begin bad++; $display("FAIL seq_addr2 got=%h exp=108", imem_addr); end
        total++; if (ifid_pc4 !== 32'h108 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL seq_ifid2 got=%h/%b exp=108/1", ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] hInstr, hPc4;
        jump_en = 1'b1; jump_target = 32'h20;
        cycle();
        setIdle();
        cycle();                            // pc now 0x24 - go back to 0x20
        jump_en = 1'b1; jump_target = 32'h1C;
        cycle();
        setIdle();
        cycle();                            // IF/ID holds 0x1C, pc = 0x20
        hInstr = ifid_instr; hPc4 = ifid_pc4;
        pc_write = 1'b0; ifid_write = 1'b0;
        cycle();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL loaduse_pc got=%h exp=20", pc); end
        total++; if (ifid_instr !== memWord(32'h1C) || ifid_pc4 !== 32'h20 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL loaduse_hold got=%h/%h/%b exp=%h/20/1", ifid_instr, ifid_pc4, ifid_valid, memWord(32'h1C));
        end
        setIdle();
        cycle();
        total++; if (pc !== 32'h24 || ifid_pc4 !== 32'h24 || ifid_instr !== memWord(32'h20)) begin
            bad++; $display("FAIL loaduse_resume got=%h/%h/%h exp=24/24/%h", pc, ifid_pc4, ifid_instr, memWord(32'h20));
        end
        cycle();
        total++; if (ifid_pc4 !== 32'h28) begin bad++; $display("FAIL loaduse_nodup got=%h exp=28 (prev %h)", ifid_pc4, hPc4); end
        if (hInstr === 32'hx) $display("note: held instr unknown");
    endtask

    task automatic test_branch_priority();
        branch_taken = 1'b1; branch_target = 32'h400;
        ifid_write = 1'b0; jump_en = 1'b1; jump_target = 32'h800;
        cycle();
        total++; if (pc !== 32'h400) begin bad++; $display("FAIL branch_pc got=%h exp=400", pc); end
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
            bad++; $display("FAIL branch_flush got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOP);
        end
        setIdle();
        cycle();
        total++; if (pc !== 32'h404 || ifid_instr !== memWord(32'h400) || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL branch_target_fetch got=%h/%h/%b exp=404/%h/1", pc, ifid_instr, ifid_valid, memWord(32'h400));
        end
    endtask

    task automatic test_jump();
        jump_en = 1'b1; jump_target = 32'h203;
        cycle();
        total++; if (pc !== 32'h200 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL jump_bubble got=%h/%b exp=200/0", pc, ifid_valid);
        end
        setIdle();
        cycle();
        total++; if (ifid_instr !== memWord(32'h200) || ifid_pc4 !== 32'h204 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL jump_first got=%h/%h/%b exp=%h/204/1", ifid_instr, ifid_pc4, ifid_valid, memWord(32'h200));
        end
    endtask

    task automatic test_imem_wait();
        logic [31:0] s0;
        jump_en = 1'b1; jump_target = 32'h40;
        cycle();
        setIdle();
        s0 = perf_stall_cnt;
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++; if (pc !== 32'h40 || imem_addr !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
                bad++; $display("FAIL wait_bubble%0d got=%h/%b/%h exp=40/0/%h", k, pc, ifid_valid, ifid_instr, NOP);
            end
        end
        total++; if (perf_stall_cnt - s0 !== perfExp(32'd3)) begin
            bad++; $display("FAIL wait_stallcnt got=%0d exp=%0d", perf_stall_cnt - s0, perfExp(32'd3));
        end
        imem_ready = 1'b1;
        cycle();
        total++; if (pc !== 32'h44 || ifid_instr !== memWord(32'h40) || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL wait_resume got=%h/%h/%b exp=44/%h/1", pc, ifid_instr, ifid_valid, memWord(32'h40));
        end
    endtask

    task automatic test_wrap();
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFF;
        cycle();
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h exp=fffffffc", pc); end
        setIdle();
        cycle();
        total++; if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL wrap_advance got=%h/%h/%b exp=0/0/1", pc, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            pc_write      = ($urandom_range(0, 4) != 0);
            ifid_write    = ($urandom_range(0, 4) != 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump_en       = ($urandom_range(0, 7) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            cycle();
            total++;
            if (pc !== mPc || imem_addr !== mPc || ifid_valid !== mValid || ifid_instr !== mInstr
                || (mValid && ifid_pc4 !== mPc4)) begin
                bad++;
                $display("FAIL rand_state n=%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h", n, pc, ifid_instr, ifid_valid, ifid_pc4,
                         mPc, mInstr, mValid, mPc4);
            end
            total++;
            if (perf_fetch_cnt !== perfExp(mFetch) || perf_stall_cnt !== perfExp(mStall)
                || perf_flush_cnt !== perfExp(mFlush)) begin
                bad++;
                $display("FAIL rand_perf n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, perf_fetch_cnt, perf_stall_cnt,
                         perf_flush_cnt, perfExp(mFetch), perfExp(mStall), perfExp(mFlush));
            end
        end
        setIdle();
    endtask

    task automatic test_async_reset();
        pc_write = 1'b0; ifid_write = 1'b0;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pc !== RST_PC || ifid_instr !== NOP || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%h/%h/%b exp=%h/%h/0/0", pc, ifid_instr, ifid_pc4, ifid_valid, RST_PC, NOP);
        end
        total++; if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
            bad++; $display("FAIL async_reset_perf got=%h/%h/%h exp=0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
        #2;
        rst_n = 1'b1;
        modelReset();
        setIdle();
        cycle();
        total++; if (pc !== 32'h104 || ifid_pc4 !== 32'h104 || ifid_instr !== memWord(RST_PC) || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL post_reset_fetch got=%h/%h/%b exp=104/104/1", pc, ifid_pc4, ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_imem_wait();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter and the IF/ID pipeline register. It consumes the stall controls from the load-use hazard unit (`pc_write`, `ifid_write`), applies branch/jump redirects and instruction-memory wait states, and delivers instruction, PC+4 and a valid bit to the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, encoding injected on bubbles/flushes (sll $0,$0,0)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  async active-low reset
- `pc_write`  in  1  from hazard unit; 0 = hold PC
- `ifid_write`  in  1  from hazard unit; 0 = hold IF/ID
- `branch_taken`  in  1  branch resolved taken in EX
- `branch_target`  in  32  branch destination
- `jump_en`  in  1  J/JAL/JR decoded in ID
- `jump_target`  in  32  jump destination
- `imem_addr`  out  32  fetch address (= PC register, combinational)
- `imem_rdata`  in  32  instruction for `imem_addr`, same cycle
- `imem_ready`  in  1  `imem_rdata` valid this cycle
- `pc`  out  32  current PC register
- `ifid_instr`  out  32  registered instruction to ID
- `ifid_pc4`  out  32  registered fetch PC + 4
- `ifid_valid`  out  1  1 = real instruction, 0 = bubble
- `perf_fetch_cnt`, `perf_stall_cnt`, `perf_flush_cnt`  out  32 each  performance counters (see Configuration)

## Operation
- Reset (async): `pc`=RESET_PC, `ifid_instr`=NOP_INSTR, `ifid_pc4`=0, `ifid_valid`=0, all perf counters 0.
- `jump_acc` = `jump_en & ifid_write` (a jump in a stalled ID slot is not yet issued and is ignored).
- Next PC, priority high→low: `branch_taken` → `branch_target`; `jump_acc` → `jump_target`; `!pc_write | !imem_ready` → hold; else `pc + 4`.
- Redirect overrides `pc_write`/`imem_ready`; bits [1:0] of any target forced to 0.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- IF/ID update, priority high→low:
  - `branch_taken` or `jump_acc`: flush — instr=NOP_INSTR, valid=0, pc4 unchanged (don't care); flush wins over `ifid_write`=0.
  - `ifid_write`=0: hold all three fields.
  - `imem_ready`=0: bubble — instr=NOP_INSTR, valid=0.
  - else load `imem_rdata`, `pc+4`, valid=1.
- Fetch state is implicit in (pc, valid); no hidden state beyond the registers listed.

## Timing
- Fetch latency 1 cycle: instruction at `imem_addr` in cycle N appears on `ifid_*` after edge N+1.
- Redirect in cycle N: `imem_addr`=target in N+1; first target instruction on `ifid_*` after N+2; exactly one bubble for a jump; branch from EX costs the IF/ID flush (ID/EX flush is owned by the ID stage).
- Stall asserted for K cycles: PC and IF/ID frozen K cycles, no instruction lost or duplicated.
- `imem_ready` low K cycles: K bubbles, PC held, same address re-presented.
- Reset deasserted asynchronously-safe: first rising edge after release fetches RESET_PC; reset mid-stall discards all state.

## Configuration
- `IF_PERF_CNT_EN` defined: `perf_fetch_cnt` +1 per IF/ID load with valid=1; `perf_stall_cnt` +1 per cycle with `ifid_write`=0 or `imem_ready`=0 (no redirect); `perf_flush_cnt` +1 per flush. All saturate at 32'hFFFF_FFFF, reset to 0.
- Not defined: counter logic absent, ports remain and drive constant 0.

## Structure
- Shared `cpu_pkg`: XLEN=32, NOP_INSTR encoding, PC_INC=4.
- One sub-module: `if_perf_cnt` (three saturating counters, instantiated only under `IF_PERF_CNT_EN`).

## Test plan
- Reset, RESET_PC=0x100, ready=1, no stalls → `imem_addr` 0x100,0x104,0x108; `ifid_pc4` 0x104 then 0x108, valid=1.
- Load-use: `pc_write`=`ifid_write`=0 for 1 cycle at PC 0x20 → PC stays 0x20, IF/ID holds, next cycle resumes 0x24, no duplicate.
- `branch_taken`=1, target 0x400, simultaneous `ifid_write`=0 and `jump_en`=1 → PC 0x400, IF/ID flushed (valid=0, NOP), jump ignored.
- `jump_en`=1 target 0x203 with `ifid_write`=1 → PC 0x200, one bubble, then instr from 0x200.
- `imem_ready`=0 for 3 cycles at 0x40 → 3 bubbles, PC 0x40 held; with `IF_PERF_CNT_EN`, `perf_stall_cnt`=3.
- PC=0xFFFF_FFFC advance → PC 0x0000_0000, `ifid_pc4`=0x0000_0000; async reset mid-stall → all outputs at reset values immediately.
